// File: rtl/jacobian_to_affine.sv
// Jacobian (X, Y, Z) to affine (X/Z^2, Y/Z^3) mod m conversion.
// One binary modular inverter feeding a bit-serial multiplier reused four times.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for start, outputs hold reset values
// S_INV    | binary extended inversion of Z, one step per cycle
// S_MUL_Z2 | t2 = zi * zi
// S_MUL_Z3 | t3 = t2 * zi
// S_MUL_X  | ax = px * t2
// S_MUL_Y  | ay = py * t3
// S_DONE   | result held, ready rises one cycle after entry
module jacobian_to_affine #(
   parameter int N = 256
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         start_i,
   input  logic [N-1:0] px_i,
   input  logic [N-1:0] py_i,
   input  logic [N-1:0] pz_i,
   input  logic [N-1:0] m_i,
   output logic [N-1:0] ax_o,
   output logic [N-1:0] ay_o,
   output logic         inf_o,
   output logic         busy_o,
   output logic         ready_o
);

   localparam int CW = $clog2(3 * N + 1);
   localparam int BW = $clog2(N);
   localparam logic [CW-1:0] INV_CAP = CW'(3 * N - 1);
   localparam logic [BW-1:0] BIT_TOP = BW'(N - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_INV,
      S_MUL_Z2,
      S_MUL_Z3,
      S_MUL_X,
      S_MUL_Y,
      S_DONE
   } state_t;

   state_t state_q, state_d;

   logic [N-1:0]  px_q, px_d;
   logic [N-1:0]  py_q, py_d;
   logic [N-1:0]  m_q, m_d;
   logic [N-1:0]  u_q, u_d;
   logic [N-1:0]  v_q, v_d;
   logic [N-1:0]  x1_q, x1_d;
   logic [N-1:0]  x2_q, x2_d;
   logic [N-1:0]  zi_q, zi_d;
   logic [N-1:0]  t2_q, t2_d;
   logic [N-1:0]  t3_q, t3_d;
   logic [N-1:0]  acc_q, acc_d;
   logic [N-1:0]  ax_q, ax_d;
   logic [N-1:0]  ay_q, ay_d;
   logic [CW-1:0] inv_cnt_q, inv_cnt_d;
   logic [BW-1:0] bit_q, bit_d;
   logic          inf_q, inf_d;
   logic          ready_q, ready_d;

   logic [N-1:0]  a_mul;
   logic [N-1:0]  b_mul;
   logic [N-1:0]  acc_nx;
   logic          mul_last;
   logic          accept;

   // x/2 mod m for odd m: add m first when x is odd so the shift is exact.
   function automatic logic [N-1:0] half_mod(input logic [N-1:0] x,
                                             input logic [N-1:0] md);
      logic [N:0] s;
      s = {1'b0, x} + (x[0] ? {1'b0, md} : {(N + 1){1'b0}});
      return s[N:1];
   endfunction

   function automatic logic [N-1:0] sub_mod(input logic [N-1:0] a,
                                            input logic [N-1:0] b,
                                            input logic [N-1:0] md);
      logic [N:0] d;
      d = {1'b0, a} - {1'b0, b};
      if (d[N]) begin
         d = d + {1'b0, md};
      end
      return d[N-1:0];
   endfunction

   function automatic logic [N-1:0] mul_step(input logic [N-1:0] acc,
                                             input logic [N-1:0] a,
                                             input logic         b,
                                             input logic [N-1:0] md);
      logic [N:0] t;
      t = {acc, 1'b0};
      if (t >= {1'b0, md}) begin
         t = t - {1'b0, md};
      end
      if (b) begin
         t = t + {1'b0, a};
         if (t >= {1'b0, md}) begin
            t = t - {1'b0, md};
         end
      end
      return t[N-1:0];
   endfunction

   always_comb begin
      a_mul = '0;
      b_mul = '0;
      case (state_q)
         S_MUL_Z2: begin a_mul = zi_q; b_mul = zi_q; end
         S_MUL_Z3: begin a_mul = t2_q; b_mul = zi_q; end
         S_MUL_X:  begin a_mul = px_q; b_mul = t2_q; end
         S_MUL_Y:  begin a_mul = py_q; b_mul = t3_q; end
         default:  begin a_mul = '0;   b_mul = '0;   end
      endcase
   end

   assign acc_nx   = mul_step(acc_q, a_mul, b_mul[bit_q], m_q);
   assign mul_last = (bit_q == '0);
   assign accept   = start_i && ((state_q == S_IDLE) || (state_q == S_DONE));

   always_comb begin
      state_d   = state_q;
      px_d      = px_q;
      py_d      = py_q;
      m_d       = m_q;
      u_d       = u_q;
      v_d       = v_q;
      x1_d      = x1_q;
      x2_d      = x2_q;
      zi_d      = zi_q;
      t2_d      = t2_q;
      t3_d      = t3_q;
      acc_d     = acc_q;
      ax_d      = ax_q;
      ay_d      = ay_q;
      inv_cnt_d = inv_cnt_q;
      bit_d     = bit_q;
      inf_d     = inf_q;
      ready_d   = ready_q;

      case (state_q)
         S_INV: begin
            if (u_q == N'(1)) begin
               zi_d    = x1_q;
               state_d = S_MUL_Z2;
            end else if (v_q == N'(1)) begin
               zi_d    = x2_q;
               state_d = S_MUL_Z2;
            end else if (inv_cnt_q == '0) begin
               // Bad operands never converge; bail out with a zero inverse.
               zi_d    = '0;
               state_d = S_MUL_Z2;
            end else begin
               inv_cnt_d = inv_cnt_q - 1'b1;
               if (!u_q[0]) begin
                  u_d  = u_q >> 1;
                  x1_d = half_mod(x1_q, m_q);
               end else if (!v_q[0]) begin
                  v_d  = v_q >> 1;
                  x2_d = half_mod(x2_q, m_q);
               end else if (u_q >= v_q) begin
                  u_d  = u_q - v_q;
                  x1_d = sub_mod(x1_q, x2_q, m_q);
               end else begin
                  v_d  = v_q - u_q;
                  x2_d = sub_mod(x2_q, x1_q, m_q);
               end
            end
            acc_d = '0;
            bit_d = BIT_TOP;
         end
         S_MUL_Z2, S_MUL_Z3, S_MUL_X, S_MUL_Y: begin
            acc_d = acc_nx;
            bit_d = bit_q - 1'b1;
            if (mul_last) begin
               acc_d = '0;
               bit_d = BIT_TOP;
               case (state_q)
                  S_MUL_Z2: begin t2_d = acc_nx; state_d = S_MUL_Z3; end
                  S_MUL_Z3: begin t3_d = acc_nx; state_d = S_MUL_X;  end
                  S_MUL_X:  begin ax_d = acc_nx; state_d = S_MUL_Y;  end
                  default:  begin ay_d = acc_nx; state_d = S_DONE;   end
               endcase
            end
         end
         S_DONE: begin
            ready_d = 1'b1;
         end
         default: begin
            state_d = state_q;
         end
      endcase

      if (accept) begin
         px_d    = px_i;
         py_d    = py_i;
         m_d     = m_i;
         ready_d = 1'b0;
         if (pz_i == '0) begin
            inf_d   = 1'b1;
            ax_d    = '0;
            ay_d    = '0;
            state_d = S_DONE;
         end else begin
            inf_d     = 1'b0;
            u_d       = pz_i;
            v_d       = m_i;
            x1_d      = N'(1);
            x2_d      = '0;
            inv_cnt_d = INV_CAP;
            state_d   = S_INV;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= S_IDLE;
         px_q      <= '0;
         py_q      <= '0;
         m_q       <= '0;
         u_q       <= '0;
         v_q       <= '0;
         x1_q      <= '0;
         x2_q      <= '0;
         zi_q      <= '0;
         t2_q      <= '0;
         t3_q      <= '0;
         acc_q     <= '0;
         ax_q      <= '0;
         ay_q      <= '0;
         inv_cnt_q <= '0;
         bit_q     <= '0;
         inf_q     <= 1'b0;
         ready_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         px_q      <= px_d;
         py_q      <= py_d;
         m_q       <= m_d;
         u_q       <= u_d;
         v_q       <= v_d;
         x1_q      <= x1_d;
         x2_q      <= x2_d;
         zi_q      <= zi_d;
         t2_q      <= t2_d;
         t3_q      <= t3_d;
         acc_q     <= acc_d;
         ax_q      <= ax_d;
         ay_q      <= ay_d;
         inv_cnt_q <= inv_cnt_d;
         bit_q     <= bit_d;
         inf_q     <= inf_d;
         ready_q   <= ready_d;
      end
   end

   assign ax_o    = ax_q;
   assign ay_o    = ay_q;
   assign inf_o   = inf_q;
   assign ready_o = ready_q;
   assign busy_o  = (state_q != S_IDLE) && (state_q != S_DONE);

endmodule
